seg7_scan_ctrl: RTL and testbench

Scan scheduler for the 4-digit, common-anode 7-segment display. It time-multiplexes one shared segment bus across the four anodes and inserts all-off dead time between digits. It double-buffers the displayed value through a valid/ready load port, so updates never tear mid-frame. It sits between the counter/value logic and the board pins, and it owns seg, an and dp.

---
 rtl/seg7_scan_ctrl_if.sv | 11 +
 rtl/seg7_scan_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_ctrl_if.sv
// Double-buffered load port of the 7-segment scan controller.
// The producer drives value, decimal points and valid; the controller answers with ready.
interface seg7_scan_ctrl_if;
    logic [15:0] din;
    logic [3:0]  dp_in;
    logic        din_valid;
    logic        din_ready;

    modport master (output din, dp_in, din_valid, input din_ready);
    modport slave  (input din, dp_in, din_valid, output din_ready);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Scan scheduler for a 4-digit common-anode 7-segment display with dead time,
// leading-zero blanking and a shadow buffer swapped only at frame boundaries.
module seg7_scan_ctrl #(
    parameter int unsigned DIV  = 100000,
    parameter int unsigned DEAD = 2,
    parameter bit          LZB  = 1'b1
) (
    input  logic            clk_in,
    input  logic            rst,
    input  logic [2:0]      sel_an,
    seg7_scan_ctrl_if.slave ld,
    output logic [6:0]      seg,
    output logic            dp,
    output logic [3:0]      an,
    output logic            frame_done
);
    localparam int unsigned CW        = $clog2(DIV + DEAD + 1);
    localparam int unsigned DEAD_LAST = (DEAD == 0) ? 0 : DEAD - 1;

    typedef enum logic [1:0] {S_ON, S_DEAD, S_IDLE} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [2:0]    nact_q, nact_d;
    logic [15:0]   act_val_q, act_val_d, sh_val_q, sh_val_d;
    logic [3:0]    act_dp_q, act_dp_d, sh_dp_q, sh_dp_d;
    logic          pend_q, pend_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic [3:0]    an_q, an_d;
    logic          fd_q, fd_d;

    logic          boundary, last_digit, xfer, blank;
    logic [2:0]    sel_clamp;
    logic [3:0]    nib, nz;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'b1000000;
            4'h1: decode = 7'b1111001;
            4'h2: decode = 7'b0100100;
            4'h3: decode = 7'b0110000;
            4'h4: decode = 7'b0011001;
            4'h5: decode = 7'b0010010;
            4'h6: decode = 7'b0000010;
            4'h7: decode = 7'b1111000;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0010000;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b0000011;
            4'hC: decode = 7'b1000110;
            4'hD: decode = 7'b0100001;
            4'hE: decode = 7'b0000110;
            default: decode = 7'b0001110;
        endcase
    endfunction

    assign sel_clamp    = (sel_an > 3'd4) ? 3'd4 : sel_an;
    assign last_digit   = (({1'b0, idx_q} + 3'd1) == nact_q);
    assign xfer         = ld.din_valid & ~pend_q;
    assign ld.din_ready = ~pend_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        idx_d    = idx_q;
        boundary = 1'b0;
        case (state_q)
            S_ON: begin
                if (cnt_q == CW'(DIV - 1)) begin
                    cnt_d = '0;
                    if (DEAD != 0) begin
                        state_d = S_DEAD;
                    end else if (last_digit) begin
                        boundary = 1'b1;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            S_DEAD: begin
                if (cnt_q == CW'(DEAD_LAST)) begin
                    cnt_d = '0;
                    if (last_digit) begin
                        boundary = 1'b1;
                    end else begin
                        state_d = S_ON;
                        idx_d   = idx_q + 2'd1;
                    end
                end
            end
            default: begin
                if (cnt_q == CW'(DIV + DEAD - 1)) begin
                    boundary = 1'b1;
                end
            end
        endcase
        if (boundary) begin
            cnt_d   = '0;
            idx_d   = '0;
            state_d = (sel_clamp == 3'd0) ? S_IDLE : S_ON;
        end
    end

    // Shadow fills on a transfer; it moves to the active copy only at a boundary.
    always_comb begin
        sh_val_d  = sh_val_q;
        sh_dp_d   = sh_dp_q;
        act_val_d = act_val_q;
        act_dp_d  = act_dp_q;
        pend_d    = pend_q;
        nact_d    = nact_q;
        if (boundary) begin
            nact_d = sel_clamp;
            if (pend_q) begin
                act_val_d = sh_val_q;
                act_dp_d  = sh_dp_q;
                pend_d    = 1'b0;
            end
        end
        if (xfer) begin
            sh_val_d = ld.din;
            sh_dp_d  = ld.dp_in;
            pend_d   = 1'b1;
        end
    end

    // A digit is blanked when it and every higher active digit hold zero.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            nz[i] = |act_val_q[i*4 +: 4];
        end
        blank = 1'b0;
        if (LZB && idx_q != 2'd0) begin
            blank = 1'b1;
            for (int unsigned i = 0; i < 4; i++) begin
                if (i >= 32'(idx_q) && i < 32'(nact_q) && nz[i]) begin
                    blank = 1'b0;
                end
            end
        end
        nib  = act_val_q[{idx_q, 2'b00} +: 4];
        an_d = 4'hF;
        seg_d = 7'h7F;
        dp_d = 1'b1;
        fd_d = boundary;
        if (state_q == S_ON) begin
            an_d[idx_q] = 1'b0;
            seg_d       = blank ? 7'h7F : decode(nib);
            dp_d        = ~act_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q   <= S_ON;
            cnt_q     <= '0;
            idx_q     <= '0;
            nact_q    <= 3'd4;
            act_val_q <= '0;
            act_dp_q  <= '0;
            sh_val_q  <= '0;
            sh_dp_q   <= '0;
            pend_q    <= 1'b0;
            an_q      <= 4'hF;
            seg_q     <= 7'h7F;
            dp_q      <= 1'b1;
            fd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            nact_q    <= nact_d;
            act_val_q <= act_val_d;
            act_dp_q  <= act_dp_d;
            sh_val_q  <= sh_val_d;
            sh_dp_q   <= sh_dp_d;
            pend_q    <= pend_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            fd_q      <= fd_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_done = fd_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: two instances (blanking on/off) compared every cycle
// against a frame-position model of the scan schedule.
module tb_seg7_scan_ctrl;
    localparam int DIV  = 4;
    localparam int DEAD = 1;
    localparam int P    = DIV + DEAD;
    localparam logic [6:0] SEG_TAB [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  sel_an = 3'd4;
    logic [15:0] din = '0;
    logic [3:0]  dp_in = '0;
    logic        din_valid = 1'b0;

    logic [6:0] seg_a, seg_b;
    logic       dp_a, dp_b, fd_a, fd_b;
    logic [3:0] an_a, an_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: position within the current frame plus the buffered data.
    int          m_pos, m_nact;
    logic        m_idle, m_pend;
    logic [31:0] m_val, m_shv;
    logic [3:0]  m_dp, m_shd;

    seg7_scan_ctrl_if ifa ();
    seg7_scan_ctrl_if ifb ();
    assign ifa.din = din;
    assign ifa.dp_in = dp_in;
    assign ifa.din_valid = din_valid;
    assign ifb.din = din;
    assign ifb.dp_in = dp_in;
    assign ifb.din_valid = din_valid;

    seg7_scan_ctrl #(.DIV(DIV), .DEAD(DEAD), .LZB(1'b1)) dut_a (
        .clk_in(clk), .rst(rst), .sel_an(sel_an), .ld(ifa),
        .seg(seg_a), .dp(dp_a), .an(an_a), .frame_done(fd_a));

    seg7_scan_ctrl #(.DIV(DIV), .DEAD(DEAD), .LZB(1'b0)) dut_b (
        .clk_in(clk), .rst(rst), .sel_an(sel_an), .ld(ifb),
        .seg(seg_b), .dp(dp_b), .an(an_b), .frame_done(fd_b));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_nact = 4; m_idle = 1'b0; m_pend = 1'b0;
        m_val = '0; m_dp = '0; m_shv = '0; m_shd = '0;
    endtask

    task automatic step();
        logic [3:0]  e_an;
        logic [6:0]  e_sa, e_sb;
        logic        e_dp, e_fd, bnd, xfer, blank;
        logic [31:0] shifted, masked;
        int          slot;
        e_an = 4'hF; e_sa = 7'h7F; e_sb = 7'h7F; e_dp = 1'b1; e_fd = 1'b0; bnd = 1'b0;
        if (!rst) begin
            bnd  = m_idle ? (m_pos == P - 1) : (m_pos == m_nact * P - 1);
            e_fd = bnd;
            if (!m_idle && (m_pos % P) < DIV) begin
                slot    = m_pos / P;
                e_an    = ~(4'b0001 << slot);
                shifted = m_val >> (4 * slot);
                masked  = m_val & ((32'd1 << (4 * m_nact)) - 32'd1);
                blank   = (slot > 0) && ((masked >> (4 * slot)) == 32'd0);
                e_sb    = SEG_TAB[shifted[3:0]];
                e_sa    = blank ? 7'h7F : e_sb;
                e_dp    = ~m_dp[slot];
            end
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            xfer = din_valid && !m_pend;
            if (bnd) begin
                if (m_pend) begin
                    m_val = m_shv; m_dp = m_shd; m_pend = 1'b0;
                end
                m_nact = (sel_an > 3'd4) ? 4 : int'(sel_an);
                m_idle = (m_nact == 0);
                m_pos  = 0;
            end else begin
                m_pos++;
            end
            if (xfer) begin
                m_shv = {16'h0, din}; m_shd = dp_in; m_pend = 1'b1;
            end
        end
        #1;
        chk("an_lzb", 16'(an_a), 16'(e_an));
        chk("an_nolzb", 16'(an_b), 16'(e_an));
        chk("seg_lzb", 16'(seg_a), 16'(e_sa));
        chk("seg_nolzb", 16'(seg_b), 16'(e_sb));
        chk("dp_lzb", 16'(dp_a), 16'(e_dp));
        chk("dp_nolzb", 16'(dp_b), 16'(e_dp));
        chk("frame_done_lzb", 16'(fd_a), 16'(e_fd));
        chk("frame_done_nolzb", 16'(fd_b), 16'(e_fd));
        chk("din_ready_lzb", 16'(ifa.din_ready), 16'(!m_pend));
        chk("din_ready_nolzb", 16'(ifb.din_ready), 16'(!m_pend));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] d);
        din = v; dp_in = d; din_valid = 1'b1;
        step();
        din_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        run(5);
        rst = 1'b0;
        run(8);

        load(16'h1234, 4'b0000);
        run(45);

        // Width change mid-frame, clamping, and the idle schedule.
        run(7);
        sel_an = 3'd2;
        run(40);
        sel_an = 3'd7;
        run(45);
        sel_an = 3'd0;
        run(40);
        sel_an = 3'd4;
        run(30);

        // Back-to-back loads with valid held high.
        din = 16'h1111; dp_in = 4'b0001; din_valid = 1'b1;
        step();
        din = 16'h2222; dp_in = 4'b0010;
        run(45);
        din_valid = 1'b0;
        run(25);

        load(16'h0070, 4'b1000);
        run(45);
        sel_an = 3'd3;
        run(40);
        sel_an = 3'd4;
        run(25);

        // Reset during digit 2 while a loaded value is still pending.
        for (int i = 0; i < 40; i++) begin
            if (m_pos == 0 && !m_idle) break;
            step();
        end
        load(16'hBEEF, 4'b1111);
        for (int i = 0; i < 40; i++) begin
            if (m_pos == 2 * P + 2) break;
            step();
        end
        chk("pending_before_rst", 16'(ifa.din_ready), 16'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(25);

        // Random traffic, width changes and occasional resets.
        for (int i = 0; i < 600; i++) begin
            din       = 16'($urandom);
            dp_in     = 4'($urandom);
            din_valid = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 39) == 0) sel_an = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) din = {12'h0, 4'($urandom)};
            rst = ($urandom_range(0, 249) == 0);
            step();
        end
        rst = 1'b0;
        din_valid = 1'b0;
        run(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
